// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one SRAM controller between two requesters: port 0 (MEM stage data
// accesses) and port 1 (instruction fetch / loader). Whole 32-bit
// transactions are serialised. The controller sees one stable request at a
// time. Read data is returned to the port that issued the read.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   wr_enN, rd_enN             port N write/read request (level, held until readyN)
//   addressN, write_dataN      port N byte address and write data
//   read_dataN                 port N read data (live while served, else last capture)
//   readyN                     port N freeze, 0 = stall
//   mem_wr_en, mem_rd_en       request to the SRAM controller
//   mem_address, mem_write_data
//   mem_read_data, mem_ready   controller response, mem_ready marks the final cycle
//   grant                      one-hot current owner, 00 while idle
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests. Without it port 0 has fixed priority.
`timescale 1ns/1ps
module sram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en0,
  input  logic        rd_en0,
  input  logic [31:0] address0,
  input  logic [31:0] write_data0,
  output logic [31:0] read_data0,
  output logic        ready0,
  input  logic        wr_en1,
  input  logic        rd_en1,
  input  logic [31:0] address1,
  input  logic [31:0] write_data1,
  output logic [31:0] read_data1,
  output logic        ready1,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        last_grant, last_grant_nxt;  // 1 = port 1 won most recently
  logic [31:0] read_data0_q, read_data1_q;
  logic        cap0, cap1;
  logic        req0, req1;
  logic        pick1;

  assign req0 = wr_en0 | rd_en0;
  assign req1 = wr_en1 | rd_en1;

`ifdef SRAM_ARB_RR_EN
  // On a tie the port that did not win last time is chosen.
  assign pick1 = req1 & (~req0 | ~last_grant);
`else
  assign pick1 = req1 & ~req0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      read_data0_q <= 32'd0;
      read_data1_q <= 32'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      if (cap0) read_data0_q <= mem_read_data;
      if (cap1) read_data1_q <= mem_read_data;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cap0           = 1'b0;
    cap1           = 1'b0;
    grant          = 2'b00;
    mem_wr_en      = 1'b0;
    mem_rd_en      = 1'b0;
    mem_address    = 32'd0;
    mem_write_data = 32'd0;
    case (state)
      IDLE: begin
        // mem_ready is ignored here; enables stay low for at least this
        // cycle so the controller returns to its first phase.
        if (req0 | req1) begin
          state_nxt      = pick1 ? BUSY1 : BUSY0;
          last_grant_nxt = pick1;
        end
      end
      BUSY0: begin
        grant          = 2'b01;
        mem_wr_en      = wr_en0;
        mem_rd_en      = rd_en0 & ~wr_en0;
        mem_address    = address0;
        mem_write_data = write_data0;
        // A dropped request is a pipeline flush: abandon without capture.
        if (!req0) begin
          state_nxt = IDLE;
        end else if (mem_ready) begin
          state_nxt = IDLE;
          cap0      = ~wr_en0;
        end
      end
      BUSY1: begin
        grant          = 2'b10;
        mem_wr_en      = wr_en1;
        mem_rd_en      = rd_en1 & ~wr_en1;
        mem_address    = address1;
        mem_write_data = write_data1;
        if (!req1) begin
          state_nxt = IDLE;
        end else if (mem_ready) begin
          state_nxt = IDLE;
          cap1      = ~wr_en1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready0     = ~req0 | ((state == BUSY0) & mem_ready);
  assign ready1     = ~req1 | ((state == BUSY1) & mem_ready);
  assign read_data0 = (state == BUSY0) ? mem_read_data : read_data0_q;
  assign read_data1 = (state == BUSY1) ? mem_read_data : read_data1_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single SRAM controller between two pipeline requesters: port 0, the MEM stage (data), and port 1, the secondary master (instruction fetch / loader). It serialises whole 32-bit transactions and presents the downstream controller with one stable request at a time. It also drives a per-port `ready` freeze signal and returns read data to the requester that issued the read. It sits between the requesters and the SRAM controller's `wr_en`/`rd_en`/`address`/`writeData`/`readData`/`ready` port.

## Interface
- No parameters. Data and address widths are fixed at 32.
- Reset is `rst`: synchronous, active-high. Clock is `clk`.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous active-high reset.
- `wr_en0`, `rd_en0` input 1 each: port 0 write / read request, level, held until `ready0`=1.
- `address0` input 32: port 0 byte address, passed through unmodified.
- `write_data0` input 32: port 0 write data.
- `read_data0` output 32: port 0 read data.
- `ready0` output 1: port 0 freeze; 0 means stall.
- `wr_en1`, `rd_en1`, `address1`, `write_data1`, `read_data1`, `ready1`: same as port 0, for port 1.
- `mem_wr_en`, `mem_rd_en` output 1 each: to controller.
- `mem_address` output 32: to controller.
- `mem_write_data` output 32: to controller.
- `mem_read_data` input 32: from controller; valid in the cycle `mem_ready`=1.
- `mem_ready` input 1: from controller; 1 in the final cycle of a transaction.
- `grant` output 2: one-hot current owner; 00 when IDLE.

## Operation
- A port requests when `reqN = wr_enN | rd_enN`. If both enables are high, the transaction is a write.
- State machine has three states: IDLE, BUSY0, BUSY1. Reset enters IDLE.
- IDLE:
  - `mem_wr_en`=`mem_rd_en`=0, `mem_address`=0, `mem_write_data`=0. Deasserted enables let the controller return to its first phase.
  - If any request is present, register the winner and go to BUSYn. Otherwise stay in IDLE.
- BUSYn:
  - `mem_*` outputs are a combinational mux of port n's live inputs.
  - If `mem_ready`=1 and `reqN`=1, the transaction completes: go to IDLE and capture `mem_read_data` into `read_dataN_q` (reads only).
  - If `reqN` drops while `mem_ready`=0, this is an abort (pipeline flush): go to IDLE with no capture.
- `read_dataN` = `mem_read_data` while in BUSYn, else `read_dataN_q`. `read_dataN_q` resets to 0.
- `readyN`:
  - 1 when `reqN`=0.
  - 1 in BUSYn when `mem_ready`=1.
  - 0 otherwise, including for the port that loses arbitration.
- Mandatory IDLE cycle after every completion: a request still high in that IDLE cycle is treated as a new transaction, such as the next pipeline instruction to the same address.
- The non-granted port's inputs are ignored. Its request is held, not dropped.
- `last_grant` register (reset: port 1) records the most recent winner, updated on each IDLE→BUSY transition.

## Timing
- Request first seen in IDLE at cycle t:
  - BUSY at t+1, with `mem_*` enables asserted from t+1.
  - Controller `mem_ready` at t+5; `readyN`=1 at t+5.
  - Back to IDLE at t+6.
- Uncontended transaction: 5 stall cycles (`readyN`=0 from t to t+4).
- Contended: the loser stalls for its peer's full transaction (6 cycles) plus its own.
- Reset mid-transaction: IDLE next cycle; `mem_*` enables 0; `grant`=00; `read_data*_q`=0; `last_grant`=1.
- Reset output values:
  - `grant`=00.
  - `mem_*` outputs = 0.
  - `readyN` = !`reqN` (combinational).
  - `read_dataN` = 0.
- `mem_ready` seen in IDLE is ignored.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin. On simultaneous requests, the port ≠ `last_grant` wins. Neither port can be starved.
- `SRAM_ARB_RR_EN` undefined: fixed priority, port 0 always wins. `last_grant` is still maintained but does not affect arbitration.

## Test plan
- Port 0 read at 0x400 alone, controller model returns 0xDEADBEEF at t+5 → `ready0` low for t..t+4, high at t+5. `read_data0`=0xDEADBEEF at t+5 and held afterwards. `grant`=01 for t+1..t+5.
- Port 1 write 0x12345678 to 0x800 → `mem_wr_en`=1, `mem_address`=0x800, `mem_write_data`=0x12345678 for t+1..t+5. `ready1` rises at t+5.
- Both ports read simultaneously in IDLE from reset:
  - With `SRAM_ARB_RR_EN`: port 0 is served first (`last_grant`=1), then port 1. `ready1` stays 0 until t+11.
  - Without `SRAM_ARB_RR_EN`: port 0 wins, and repeated back-to-back port 0 requests starve port 1.
- Port 0 holds `rd_en0` high across completion for a second load → IDLE cycle at t+6 with `mem_rd_en`=0, second transaction BUSY at t+7, `ready0` high at t+11.
- Port 0 drops `rd_en0` at t+3 (flush) → IDLE at t+4, `read_data0` unchanged, a pending port 1 request is granted at t+5.
- `rst` asserted at t+3 of a write → next cycle `grant`=00, `mem_wr_en`=0, `read_data0`=0.
